// File: rtl/booth_div_pkg.sv
// Shared types and constants for the sequential signed divider.
// FSM state encoding, default operand width and iteration-counter sizing.
package booth_pkg;
  localparam int N_DEF = 8;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  // Counter must hold 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/booth_div_if.sv
// Operand/result handshake bundle for booth_div.
// Optional is_signed select appears when DIV_SIGNED_SEL_EN is defined.
interface booth_div_if
  import booth_pkg::*;
#(
  parameter int N = N_DEF
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
`ifdef DIV_SIGNED_SEL_EN
  logic           is_signed;
`endif
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_zero;
  logic           overflow;

  modport master (
    output in_valid, dividend, divisor,
`ifdef DIV_SIGNED_SEL_EN
    output is_signed,
`endif
    output out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor,
`ifdef DIV_SIGNED_SEL_EN
    input  is_signed,
`endif
    input  out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/booth_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// Shifts {R,Qm} left, trial-subtracts the divisor, shifts in the quotient bit.
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   r_i,
  input  logic [N-1:0] qm_i,
  input  logic [N:0]   dsr_i,
  output logic [N:0]   r_o,
  output logic [N-1:0] qm_o
);
  logic [N+1:0] shifted;
  logic [N+1:0] diff;
  logic         ge;

  // One guard bit above R so unsigned-mode divisors up to 2^n-1 still compare correctly.
  always_comb begin
    shifted = {r_i, qm_i[N-1]};
    diff    = shifted - {1'b0, dsr_i};
    ge      = ~diff[N+1];
    r_o     = ge ? diff[N:0] : shifted[N:0];
    qm_o    = {qm_i[N-2:0], ge};
  end
endmodule

// File: rtl/booth_div.sv
// Sequential signed 2n/n restoring divider, one quotient bit per clock.
// DIV_SIGNED_SEL_EN adds a per-operation signed/unsigned select.
module booth_div
  import booth_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic        clk,
  input  logic        rst,
  booth_div_if.slave  bus
);
  localparam int CW = cnt_w(N);
  localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};

  state_t         state_q, state_d;
  logic [N:0]     r_q, r_d;
  logic [N-1:0]   qm_q, qm_d;
  logic [N:0]     dsr_q, dsr_d;
  logic           sd_q, sd_d, sv_q, sv_d, sgn_q, sgn_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic           dz_q, dz_d, ov_q, ov_d;

  logic           sgn_in, sd_in, sv_in, neg_q;
  logic [2*N:0]   dvd_mag;
  logic [N:0]     dsr_mag;
  logic [N:0]     step_r;
  logic [N-1:0]   step_qm;

`ifdef DIV_SIGNED_SEL_EN
  assign sgn_in = bus.is_signed;
`else
  assign sgn_in = 1'b1;
`endif

  // Magnitudes are one bit wider so the most-negative operands stay exact.
  always_comb begin
    sd_in   = sgn_in & bus.dividend[2*N-1];
    sv_in   = sgn_in & bus.divisor[N-1];
    dvd_mag = sd_in ? -{bus.dividend[2*N-1], bus.dividend} : {1'b0, bus.dividend};
    dsr_mag = sv_in ? -{bus.divisor[N-1], bus.divisor} : {1'b0, bus.divisor};
  end

  div_step #(.N(N)) u_step (
    .r_i   (r_q),
    .qm_i  (qm_q),
    .dsr_i (dsr_q),
    .r_o   (step_r),
    .qm_o  (step_qm)
  );

  assign neg_q         = sd_q ^ sv_q;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
  assign bus.overflow  = ov_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    qm_d    = qm_q;
    dsr_d   = dsr_q;
    sd_d    = sd_q;
    sv_d    = sv_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        sd_d   = sd_in;
        sv_d   = sv_in;
        sgn_d  = sgn_in;
        r_d    = {1'b0, dvd_mag[2*N-1:N]};
        qm_d   = dvd_mag[N-1:0];
        dsr_d  = dsr_mag;
        cnt_d  = '0;
        quot_d = '0;
        rem_d  = '0;
        dz_d   = 1'b0;
        ov_d   = 1'b0;
        if (bus.divisor == '0) begin
          state_d = DONE;
          dz_d    = 1'b1;
          quot_d  = '1;
          rem_d   = bus.dividend[N-1:0];
        end else if (dvd_mag[2*N:N] >= dsr_mag) begin
          // High half already >= divisor: quotient cannot fit in n bits.
          state_d = DONE;
          ov_d    = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        r_d   = step_r;
        qm_d  = step_qm;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        quot_d  = neg_q ? -qm_q : qm_q;
        rem_d   = sd_q ? -r_q[N-1:0] : r_q[N-1:0];
        ov_d    = sgn_q & (neg_q ? (qm_q > HALF) : (qm_q >= HALF));
        if (ov_d) begin
          quot_d = '0;
          rem_d  = '0;
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      qm_q    <= '0;
      dsr_q   <= '0;
      sd_q    <= 1'b0;
      sv_q    <= 1'b0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      qm_q    <= qm_d;
      dsr_q   <= dsr_d;
      sd_q    <= sd_d;
      sv_q    <= sv_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end
endmodule

// File: tb/tb_booth_div.sv
// Directed-vector bench for booth_div (n=8): results, flags, latency, handshake, reset.
module tb_booth_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  booth_div_if #(.N(8)) bus ();
  booth_div #(.N(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // Issue one division and wait for out_valid; lat counts cycles after the accept cycle.
  task automatic do_div(input logic [15:0] a, input logic [7:0] b,
                        output logic [17:0] res, output int lat);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    res = {bus.quotient, bus.remainder, bus.div_zero, bus.overflow};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_zero, bus.overflow}
        !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h dz=%b ov=%b want 1 0 00 00 0 0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_zero, bus.overflow);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [15:0] a  [9] = '{16'h0064, 16'hFF9C, 16'h0064, 16'hFF9C, 16'h4000, 16'hC000, 16'h0100, 16'h1234, 16'h8000};
    logic [7:0]  b  [9] = '{8'h07,    8'h07,    8'hF9,    8'hF9,    8'h80,    8'h80,    8'h01,    8'h00,    8'hFF};
    logic [17:0] ex [9] = '{{8'h0E, 8'h02, 2'b00}, {8'hF2, 8'hFE, 2'b00}, {8'hF2, 8'h02, 2'b00},
                            {8'h0E, 8'hFE, 2'b00}, {8'h80, 8'h00, 2'b00}, {8'h00, 8'h00, 2'b01},
                            {8'h00, 8'h00, 2'b01}, {8'hFF, 8'h34, 2'b10}, {8'h00, 8'h00, 2'b01}};
    int          el [9] = '{10, 10, 10, 10, 10, 10, 1, 1, 1};
    logic [17:0] res;
    int          lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      do_div(a[i], b[i], res, lat);
      total++;
      if (res !== ex[i]) begin
        bad++;
        $display("FAIL vec%0d_result %h/%h got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
                 i, a[i], b[i], res[17:10], res[9:2], res[1], res[0],
                 ex[i][17:10], ex[i][9:2], ex[i][1], ex[i][0]);
      end
      total++;
      if (lat !== el[i]) begin
        bad++;
        $display("FAIL vec%0d_latency got %0d want %0d", i, lat, el[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] res;
    int          lat;
    bus.out_ready = 1'b0;
    do_div(16'h0064, 8'h07, res, lat);
    total++;
    if (res !== {8'h0E, 8'h02, 2'b00} || lat != 10) begin
      bad++;
      $display("FAIL bp_first got q=%h r=%h lat=%0d want q=0e r=02 lat=10", res[17:10], res[9:2], lat);
    end
    bus.dividend = 16'h0100;
    bus.divisor  = 8'h01;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_zero, bus.overflow}
          !== {1'b1, 1'b0, 8'h0E, 8'h02, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold%0d got vld=%b rdy=%b q=%h r=%h ov=%b want 1 0 0e 02 0",
                 c, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.overflow);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_release got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL bp_not_queued cycle %0d got vld=%b want 0", c, bus.out_valid);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [17:0] res;
    int          lat;
    bus.dividend = 16'h0064;
    bus.divisor  = 8'h07;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL rst_mid_run got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    do_div(16'h0064, 8'h07, res, lat);
    total++;
    if (res !== {8'h0E, 8'h02, 2'b00} || lat != 10) begin
      bad++;
      $display("FAIL rst_recover got q=%h r=%h dz=%b ov=%b lat=%0d want q=0e r=02 0 0 lat=10",
               res[17:10], res[9:2], res[1], res[0], lat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
`ifdef DIV_SIGNED_SEL_EN
    bus.is_signed = 1'b1;
`endif
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/booth_div.md
Name: booth_div

Overview:
- Sequential signed divider; the inverse operation of the team's unrolled Booth multiplier.
- Takes a 2n-bit two's-complement dividend (product width) and an n-bit divisor.
- Returns an n-bit quotient and an n-bit remainder using one restoring-division step per clock.
- Sits beside the multiplier in the arithmetic datapath; valid/ready on both sides.

Parameters:
- n, 8, operand width; dividend is 2n bits, divisor/quotient/remainder are n bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- dividend  input  2n  signed dividend
- divisor  input  n  signed divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  n  signed quotient, truncated toward zero
- remainder  output  n  signed remainder, same sign as dividend (or zero)
- div_zero  output  1  divisor was zero
- overflow  output  1  true quotient not representable in n bits

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - On reset: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, overflow=0.
  - Reset mid-operation abandons the division; no result is emitted.
- Handshake:
  - Accept occurs when in_valid & in_ready (cycle T).
  - in_ready=1 only in IDLE.
  - Result transfer occurs when out_valid & out_ready; the block returns to IDLE on the next cycle.
  - Outputs are held stable while out_valid=1 and out_ready=0.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE, on accept:
  - Latch sign flags: sd = dividend MSB, sv = divisor MSB.
  - Latch magnitudes |dividend| (2n+1 bit internal) and |divisor| (n+1 bit internal).
  - Clear the iteration counter.
  - If divisor==0, go to DONE with div_zero=1, quotient=all ones, remainder=dividend[n-1:0], overflow=0.
  - Else if |dividend|[2n-1:n] >= |divisor|, go to DONE with overflow=1, quotient=0, remainder=0.
  - Otherwise go to RUN.
- RUN, one step per cycle, n cycles:
  - Shift {R,Qm} left by 1.
  - Trial subtract: R - |divisor|, computed n+1 bits wide.
  - If non-negative, keep the difference and set the quotient LSB to 1; else restore and set it to 0.
  - After the nth step, go to FIX.
- FIX:
  - If sd^sv, the quotient is negated; if sd, the remainder is negated.
  - Signed range check: overflow=1 if the unsigned quotient > 2^(n-1)-1 for a positive result, or > 2^(n-1) for a negative result.
  - On overflow, quotient=0 and remainder=0.
  - Go to DONE.
- DONE: out_valid=1 until the transfer completes.
- Latency:
  - Normal result: out_valid first high at T+n+2 (T+10 for n=8).
  - Early div_zero / unsigned-overflow result: out_valid at T+1.
- Throughput: one division per n+3 cycles with out_ready held high.
- Boundary cases:
  - The most-negative dividend and divisor are handled via the widened magnitude registers.
  - in_valid asserted while busy is ignored and not queued.

Optional Feature:
- Macro DIV_SIGNED_SEL_EN.
- When defined, an extra input port is_signed (1 bit) is sampled at accept.
  - is_signed=0 treats both operands as unsigned: no abs, no FIX negation, and overflow only from the unsigned check.
  - is_signed=1 gives the behaviour above.
- When undefined, the port is absent and the block is always signed.

Decomposition:
- Shared package booth_pkg holds:
  - the FSM state typedef (IDLE/RUN/FIX/DONE, 2-bit);
  - default width constant N_DEF=8;
  - iteration-counter width function clog2(n+1).
- One natural sub-module: div_step, a combinational single restoring step.
  - Inputs: R, Qm, |divisor|.
  - Outputs: next R and next Qm.
  - Instantiated once inside the sequential loop.

Test Plan:
- Positive operands: dividend 16'h0064, divisor 8'h07 -> quotient 8'h0E, remainder 8'h02, flags 0, out_valid exactly 10 cycles after accept.
- Signs: 16'hFF9C / 8'h07 -> q 8'hF2, r 8'hFE; 16'h0064 / 8'hF9 -> q 8'hF2, r 8'h02; 16'hFF9C / 8'hF9 -> q 8'h0E, r 8'hFE.
- Range edges: 16'h4000 / 8'h80 -> q 8'h80, r 0, overflow 0; 16'hC000 / 8'h80 -> overflow 1, q 0; 16'h0100 / 8'h01 -> overflow 1 at T+1.
- Divide by zero: 16'h1234 / 8'h00 -> div_zero 1, q 8'hFF, r 8'h34, out_valid at T+1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Outputs stay stable, in_ready stays 0, and a new in_valid is ignored.
  - Release out_ready -> in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst at T+4.
  - Next cycle shows in_ready=1 and out_valid=0.
  - A fresh 16'h0064 / 8'h07 then completes correctly.
